// File: rtl/clkctrl_pkg.sv
// Shared definitions for the CPU clock generator: FSM state encoding and
// default parameter values.
package clkctrl_pkg;

  localparam int DIV_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    LS_RUN  = 2'd0,
    HS_RUN  = 2'd1,
    WAIT_LS = 2'd2
  } clk_state_e;

endpackage

// File: rtl/cpuclk_gen_if.sv
// Control/status bundle between a clock-control master and cpuclk_gen.
// hsclk_sel is a level request; the generator acknowledges it through
// hsclk_selected / lsclk_selected once the switch has actually completed.
interface cpuclk_gen_if
  import clkctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic             hsclk_sel;
  logic [DIV_W-1:0] cpuclk_div_sel;
  logic             cpuclk_out;
  logic             cpuclk_rise;
  logic             cpuclk_fall;
  logic             hsclk_selected;
  logic             lsclk_selected;
  clk_state_e       state_dbg;

  modport master (
    output hsclk_sel,
    output cpuclk_div_sel,
    input  cpuclk_out,
    input  cpuclk_rise,
    input  cpuclk_fall,
    input  hsclk_selected,
    input  lsclk_selected,
    input  state_dbg
  );

  modport slave (
    input  hsclk_sel,
    input  cpuclk_div_sel,
    output cpuclk_out,
    output cpuclk_rise,
    output cpuclk_fall,
    output hsclk_selected,
    output lsclk_selected,
    output state_dbg
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall pulses
// taken from the last stage against its one-cycle-delayed copy.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/cpuclk_gen.sv
// CPU clock generator: follows a synchronised slow bus clock or produces a
// divided copy of hsclk_in, switching glitch-free with the clock parked high.
module cpuclk_gen
  import clkctrl_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic      hsclk_in,
  input  logic      rst_b,
  input  logic      lsclk_in,
  cpuclk_gen_if.slave bus
);

  clk_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpu_q, cpu_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ls_rise;
  logic             ls_fall;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_ls_sync (
    .clk_i  (hsclk_in),
    .rst_ni (rst_b),
    .d_i    (lsclk_in),
    .rise_o (ls_rise),
    .fall_o (ls_fall)
  );

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= LS_RUN;
      cnt_q   <= '0;
      div_q   <= '0;
      cpu_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpu_q   <= cpu_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cpu_d   = cpu_q;
    case (state_q)
      LS_RUN: begin
        if (ls_rise) begin
          cpu_d = 1'b1;
          if (bus.hsclk_sel) begin
            state_d = HS_RUN;
            cnt_d   = '0;
          end
        end else if (ls_fall) begin
          cpu_d = 1'b0;
        end
      end
      HS_RUN: begin
        if (cnt_q == div_q) begin
          // A switch-out request only takes effect at the end of a high phase.
          if (cpu_q && !bus.hsclk_sel) begin
            state_d = WAIT_LS;
          end else begin
            cpu_d = ~cpu_q;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LS: begin
        // Cancellation wins over a coincident ls_fall.
        if (bus.hsclk_sel) begin
          state_d = HS_RUN;
          cnt_d   = div_q;
        end else if (ls_fall) begin
          cpu_d   = 1'b0;
          state_d = LS_RUN;
        end
      end
      default: begin
        state_d = LS_RUN;
        cnt_d   = '0;
        cpu_d   = 1'b0;
      end
    endcase
    // Ratio is captured only at a toggle, so a new value never cuts a phase short.
    if (cpu_d != cpu_q) begin
      div_d = bus.cpuclk_div_sel;
    end
    rise_d = cpu_d & ~cpu_q;
    fall_d = ~cpu_d & cpu_q;
  end

  assign bus.cpuclk_out     = cpu_q;
  assign bus.cpuclk_rise    = rise_q;
  assign bus.cpuclk_fall    = fall_q;
  assign bus.hsclk_selected = (state_q == HS_RUN);
  assign bus.lsclk_selected = (state_q == LS_RUN);
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_cpuclk_gen.sv
// Directed bench for cpuclk_gen: LS follow, HS division, ratio change,
// switch to LS, cancelled switch and reset during WAIT_LS.
module tb_cpuclk_gen;
  import clkctrl_pkg::*;

  logic clk;
  logic rst_b;
  logic lsclk_in;
  int   total;
  int   bad;
  bit   ok;

  cpuclk_gen_if #(.DIV_W(4)) bus ();

  cpuclk_gen #(
    .DIV_W       (4),
    .SYNC_STAGES (2)
  ) dut (
    .hsclk_in (clk),
    .rst_b    (rst_b),
    .lsclk_in (lsclk_in),
    .bus      (bus)
  );

  // {cpuclk_out, cpuclk_rise, cpuclk_fall, hsclk_selected, lsclk_selected}
  logic [4:0] obs;
  assign obs = {bus.cpuclk_out, bus.cpuclk_rise, bus.cpuclk_fall,
                bus.hsclk_selected, bus.lsclk_selected};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // all sampling and driving happens on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rise(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.cpuclk_rise === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_b              = 1'b0;
    lsclk_in           = 1'b0;
    bus.hsclk_sel      = 1'b0;
    bus.cpuclk_div_sel = 4'd0;
    repeat (2) tick();
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b00001);
    end
    total++;
    if (bus.state_dbg !== LS_RUN) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, LS_RUN);
    end
    rst_b = 1'b1;
  endtask

  task automatic test_ls_follow();
    logic [2:0] pipe;
    logic       prev;
    logic [4:0] exp;
    pipe = 3'b000;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp = {pipe[2], pipe[2] & ~prev, ~pipe[2] & prev, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ls_follow i=%0d got=%b exp=%b", i, obs, exp);
      end
      prev     = pipe[2];
      lsclk_in = ((i % 20) >= 10);
      pipe     = {pipe[1:0], lsclk_in};
    end
  endtask

  task automatic test_hs_div0();
    logic [4:0] tab [1:8];
    tab = '{5'b00001, 5'b00001, 5'b11010, 5'b00110,
            5'b11010, 5'b00110, 5'b11010, 5'b00110};
    bus.hsclk_sel      = 1'b1;
    bus.cpuclk_div_sel = 4'd0;
    lsclk_in           = 1'b0;
    repeat (5) tick();
    lsclk_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (obs !== tab[i]) begin
        bad++;
        $display("FAIL hs_div0 i=%0d got=%b exp=%b", i, obs, tab[i]);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [4:0] tab [0:13];
    tab = '{5'b11010, 5'b10010, 5'b00110, 5'b00010, 5'b00010, 5'b00010, 5'b11010,
            5'b10010, 5'b10010, 5'b10010, 5'b00110, 5'b00010, 5'b00010, 5'b00010};
    bus.cpuclk_div_sel = 4'd1;
    repeat (4) tick();
    wait_rise(8, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ratio_wait_rise got=0 exp=1");
    end
    bus.cpuclk_div_sel = 4'd3;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== tab[i]) begin
        bad++;
        $display("FAIL ratio_change i=%0d got=%b exp=%b", i, obs, tab[i]);
      end
    end
  endtask

  task automatic test_switch_to_ls();
    logic [4:0] tab [0:10];
    tab = '{5'b11010, 5'b10010, 5'b10010, 5'b10010, 5'b10000, 5'b10000,
            5'b10000, 5'b10000, 5'b10000, 5'b00101, 5'b00001};
    wait_rise(16, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL switch_wait_rise got=0 exp=1");
    end
    bus.hsclk_sel = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== tab[i]) begin
        bad++;
        $display("FAIL switch_to_ls i=%0d got=%b exp=%b", i, obs, tab[i]);
      end
      if (i == 4) begin
        total++;
        if (bus.state_dbg !== WAIT_LS) begin
          bad++;
          $display("FAIL switch_state got=%0d exp=%0d", bus.state_dbg, WAIT_LS);
        end
      end
      if (i == 6) lsclk_in = 1'b0;
    end
  endtask

  task automatic test_cancel();
    logic [4:0] tab [1:17];
    tab = '{5'b00001, 5'b00001, 5'b11010, 5'b10010, 5'b10010, 5'b00110,
            5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b10010, 5'b10000,
            5'b10010, 5'b00110, 5'b00010, 5'b00010, 5'b11010};
    bus.hsclk_sel      = 1'b1;
    bus.cpuclk_div_sel = 4'd2;
    repeat (2) tick();
    lsclk_in = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      total++;
      if (obs !== tab[i]) begin
        bad++;
        $display("FAIL cancel i=%0d got=%b exp=%b", i, obs, tab[i]);
      end
      if (i == 6)  bus.hsclk_sel = 1'b0;
      if (i == 10) lsclk_in = 1'b0;
      if (i == 12) bus.hsclk_sel = 1'b1;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [4:0] tab [0:3];
    tab = '{5'b11010, 5'b10010, 5'b10010, 5'b10000};
    wait_rise(12, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rstwait_wait_rise got=0 exp=1");
    end
    bus.hsclk_sel = 1'b0;
    lsclk_in      = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== tab[i]) begin
        bad++;
        $display("FAIL rstwait_entry i=%0d got=%b exp=%b", i, obs, tab[i]);
      end
    end
    #2;
    rst_b = 1'b0;
    #1;
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL rstwait_async got=%b exp=%b", obs, 5'b00001);
    end
    total++;
    if (bus.state_dbg !== LS_RUN) begin
      bad++;
      $display("FAIL rstwait_state got=%0d exp=%0d", bus.state_dbg, LS_RUN);
    end
    tick();
    rst_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (obs !== ((i == 3) ? 5'b11001 : 5'b00001)) begin
        bad++;
        $display("FAIL rstwait_first_rise i=%0d got=%b exp=%b", i, obs,
                 (i == 3) ? 5'b11001 : 5'b00001);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ls_follow();
    test_hs_div0();
    test_ratio_change();
    test_switch_to_ls();
    test_cancel();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpuclk_gen.md
CPUCLK_GEN -- requirements
Module: cpuclk_gen

Interface
REQ-001 Parameter DIV_W, default 4: width of the divide-select input.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchroniser flops on lsclk_in.
REQ-003 hsclk_in  input  1: the single clock; all flops clock on its rising edge.
REQ-004 rst_b  input  1: reset, asynchronous, active-low.
REQ-005 lsclk_in  input  1: slow bus clock, asynchronous to hsclk_in, sampled as data only.
REQ-006 hsclk_sel  input  1: 1 requests the divided high-speed CPU clock, 0 requests the slow clock.
REQ-007 cpuclk_div_sel  input  DIV_W: phase length minus one, in hsclk_in cycles, for the high-speed mode.
REQ-008 cpuclk_out  output  1: registered CPU clock level.
REQ-009 cpuclk_rise  output  1: single-cycle pulse, high in the cycle in which cpuclk_out first reads 1.
REQ-010 cpuclk_fall  output  1: single-cycle pulse, high in the cycle in which cpuclk_out first reads 0.
REQ-011 hsclk_selected  output  1: high only in state HS_RUN.
REQ-012 lsclk_selected  output  1: high only in state LS_RUN.

Function
REQ-013 lsclk_in SHALL pass through SYNC_STAGES flops; ls_rise and ls_fall are derived from the last stage against its one-cycle-delayed copy.
REQ-014 States SHALL be LS_RUN, HS_RUN and WAIT_LS.
REQ-015 LS_RUN: on ls_rise, cpuclk_out SHALL go to 1; on ls_fall, it SHALL go to 0. The resulting latency from an lsclk_in edge to cpuclk_out is SYNC_STAGES+1 cycles.
REQ-016 HS_RUN: a phase counter runs 0..div_q; when count==div_q, cpuclk_out SHALL toggle and the count SHALL reset to 0. Each phase lasts div_q+1 cycles, so the period is 2*(div_q+1).
REQ-017 div_q SHALL load cpuclk_div_sel on every cpuclk_out toggle; a new ratio therefore takes effect from the next phase only, with no truncated phase.
REQ-018 LS_RUN to HS_RUN: with hsclk_sel=1, on ls_rise, cpuclk_out SHALL go to 1 and the count SHALL be 0. That cycle is the first of the high phase.
REQ-019 HS_RUN to WAIT_LS: with hsclk_sel=0, when cpuclk_out=1 and count==div_q, the output SHALL NOT toggle; it holds high and the state moves to WAIT_LS. Clock switching always stops the clock in the high (PHI2) state.
REQ-020 WAIT_LS: cpuclk_out SHALL hold at 1. On ls_fall, cpuclk_out SHALL go to 0 and the state moves to LS_RUN.
REQ-021 WAIT_LS with hsclk_sel=1 (cancelled request): the state SHALL return to HS_RUN with count=div_q, so cpuclk_out falls on the next cycle.
REQ-022 If ls_fall and hsclk_sel=1 occur in the same WAIT_LS cycle, the cancellation (REQ-021) SHALL take priority.
REQ-023 hsclk_sel SHALL be sampled only at the decision points defined above; glitches between those points have no effect.
REQ-024 No high or low phase of cpuclk_out SHALL be shorter than one hsclk_in cycle, under any input sequence.

Reset
REQ-025 On rst_b low, the block SHALL be in state LS_RUN with:
- cpuclk_out=0, cpuclk_rise=0, cpuclk_fall=0;
- hsclk_selected=0, lsclk_selected=1;
- count=0, div_q=0, all synchroniser flops 0.
REQ-026 Reset asserted mid-phase or in WAIT_LS SHALL return the block to the REQ-025 values immediately.
REQ-027 After deassertion, the first cpuclk_out rise SHALL come from an ls_rise.

Structure
REQ-028 Package clkctrl_pkg SHALL hold the state enum and the default values of DIV_W and SYNC_STAGES.
REQ-029 Sub-module sync_edge (parametrised SYNC_STAGES synchroniser plus rise/fall detect) SHALL be instantiated once, for lsclk_in.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Reset, then lsclk_in period 20 cycles with hsclk_sel=0 -> cpuclk_out follows lsclk_in with 3-cycle lag; lsclk_selected=1.
- hsclk_sel=1, cpuclk_div_sel=0 -> after the next ls_rise, cpuclk_out period 2; hsclk_selected=1 from that cycle.
- In HS, cpuclk_div_sel changed from 1 to 3 mid high phase -> the current phase completes at 2 cycles; the following phases are 4 cycles.
- hsclk_sel=0 with cpuclk_div_sel=3 -> cpuclk_out held high from the end of the high phase until the synchronised lsclk falls; both selected outputs 0 in between.
- hsclk_sel toggled 0 then back to 1 within WAIT_LS -> return to HS; cpuclk_out falls the next cycle.
- rst_b pulsed low during WAIT_LS -> all outputs take REQ-025 values asynchronously.
